// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: active-low column drive, row sync,
// per-frame classification and press/release debounce FSM.
module keypad_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int DB_CNT   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_vld,
    output logic       key_down
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DB_CNT + 1);

    typedef enum logic [1:0] {
        IDLE,
        DEB_P,
        PRESSED,
        DEB_R
    } state_t;

    state_t         state;
    logic [3:0]     row_s1;
    logic [3:0]     row_s2;
    logic [DW-1:0]  div_cnt;
    logic [1:0]     col_idx;
    logic [1:0]     acc_n;
    logic [3:0]     acc_key;
    logic [CW-1:0]  cnt;
    logic [3:0]     cand;

    logic           dwell_end;
    logic           frame_end;
    logic [2:0]     col_hits;
    logic [1:0]     col_row;
    logic [2:0]     sum_n;
    logic [1:0]     tot_n;
    logic [3:0]     tot_key;
    logic           fr_none;
    logic           fr_single;
    logic [CW-1:0]  cnt_inc;
    logic           inc_done;

    assign dwell_end = (div_cnt == DW'(SCAN_DIV - 1));
    assign frame_end = dwell_end && (col_idx == 2'd3);
    assign col       = ~(4'b0001 << col_idx);
    assign cnt_inc   = cnt + CW'(1);
    assign inc_done  = (cnt_inc == CW'(DB_CNT));

    // acc_n saturates at 2: "two or more pressed pairs" is all MULTI needs
    always_comb begin
        col_hits = '0;
        col_row  = '0;
        for (int r = 0; r < 4; r++) begin
            if (!row_s2[r]) begin
                col_hits = col_hits + 3'd1;
                col_row  = 2'(r);
            end
        end
        sum_n = {1'b0, acc_n} + ((col_hits > 3'd2) ? 3'd2 : col_hits);
        tot_n = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
        tot_key = (acc_n == 2'd1) ? acc_key : {col_row, col_idx};
        fr_none   = (tot_n == 2'd0);
        fr_single = (tot_n == 2'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1  <= 4'b1111;
            row_s2  <= 4'b1111;
            div_cnt <= '0;
            col_idx <= '0;
            acc_n   <= '0;
            acc_key <= '0;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
            if (dwell_end) begin
                div_cnt <= '0;
                col_idx <= col_idx + 2'd1;
                acc_n   <= frame_end ? 2'd0 : tot_n;
                acc_key <= frame_end ? 4'd0 : tot_key;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cand     <= '0;
            key_code <= '0;
            key_vld  <= 1'b0;
            key_down <= 1'b0;
        end else begin
            key_vld <= 1'b0;
            if (frame_end) begin
                unique case (state)
                    IDLE: begin
                        if (fr_single) begin
                            cand <= tot_key;
                            cnt  <= CW'(1);
                            if (DB_CNT == 1) begin
                                state    <= PRESSED;
                                key_code <= tot_key;
                                key_vld  <= 1'b1;
                                key_down <= 1'b1;
                            end else begin
                                state <= DEB_P;
                            end
                        end
                    end
                    DEB_P: begin
                        if (fr_single && tot_key == cand) begin
                            cnt <= cnt_inc;
                            if (inc_done) begin
                                state    <= PRESSED;
                                key_code <= cand;
                                key_vld  <= 1'b1;
                                key_down <= 1'b1;
                            end
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                    PRESSED: begin
                        if (fr_none) begin
                            cnt <= CW'(1);
                            if (DB_CNT == 1) begin
                                state    <= IDLE;
                                key_down <= 1'b0;
                            end else begin
                                state <= DEB_R;
                            end
                        end
                    end
                    DEB_R: begin
                        if (fr_none) begin
                            cnt <= cnt_inc;
                            if (inc_done) begin
                                state    <= IDLE;
                                key_down <= 1'b0;
                            end
                        end else begin
                            state <= PRESSED;
                            cnt   <= '0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan with a matrix keypad model
// and a scoreboard of expected accepted key codes.
module tb_keypad_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_vld;
    logic       key_down;

    logic [15:0] keys = '0;
    logic [3:0]  exp_q[$];
    int checks = 0;
    int errors = 0;
    int pulses = 0;

    keypad_scan #(.SCAN_DIV(4), .DB_CNT(3)) dut (
        .clk(clk),
        .rst(rst),
        .row(row),
        .col(col),
        .key_code(key_code),
        .key_vld(key_vld),
        .key_down(key_down)
    );

    always #5 clk = ~clk;

    // key (r,c) pulls row r low while column c is driven low
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[4*r+c] && !col[c]) row[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_vld === 1'b1) begin
            logic [3:0] e;
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_vld: key_code=%0d, required no pulse", key_code);
            end else begin
                e = exp_q.pop_front();
                if (key_code !== e) begin
                    errors++;
                    $display("FAIL vld_code: got %0d, required %0d", key_code, e);
                end
            end
        end
    end

    task automatic frames(input int n);
        repeat (16 * n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_down(input string nm, input logic exp);
        checks++;
        if (key_down !== exp) begin
            errors++;
            $display("FAIL %s: key_down=%b, required %b", nm, key_down, exp);
        end
    endtask

    task automatic chk_pulses(input string nm, input int p0, input int n);
        checks++;
        if (pulses - p0 !== n) begin
            errors++;
            $display("FAIL %s: pulses=%0d, required %0d", nm, pulses - p0, n);
        end
    endtask

    task automatic test_reset();
        keys = '0;
        do_reset();
        checks++;
        if (col !== 4'b1110 || key_code !== 4'd0 || key_vld !== 1'b0 || key_down !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals: col=%b code=%0d vld=%b down=%b, required 1110 0 0 0",
                     col, key_code, key_vld, key_down);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (col !== 4'b1101) begin
            errors++;
            $display("FAIL col_step1: got %b, required 1101", col);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (col !== 4'b1011) begin
            errors++;
            $display("FAIL col_step2: got %b, required 1011", col);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (col !== 4'b1110 || key_vld !== 1'b0 || key_down !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: col=%b vld=%b down=%b, required 1110 0 0",
                     col, key_vld, key_down);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_clean_press();
        int p0;
        keys = '0;
        do_reset();
        p0 = pulses;
        keys = 16'h0001 << 6;
        exp_q.push_back(4'd6);
        frames(2);
        chk_down("clean_down_f2", 1'b0);
        frames(1);
        chk_down("clean_down_f3", 1'b1);
        checks++;
        if (key_code !== 4'd6) begin
            errors++;
            $display("FAIL clean_code: got %0d, required 6", key_code);
        end
        frames(7);
        keys = '0;
        frames(2);
        chk_down("clean_rel_f2", 1'b1);
        frames(1);
        chk_down("clean_rel_f3", 1'b0);
        frames(2);
        chk_pulses("clean_pulses", p0, 1);
        checks++;
        if (key_code !== 4'd6) begin
            errors++;
            $display("FAIL clean_hold_code: got %0d, required 6", key_code);
        end
    endtask

    task automatic test_bounce();
        int p0;
        keys = '0;
        do_reset();
        p0 = pulses;
        keys = 16'h0001 << 3;
        frames(2);
        keys = '0;
        frames(1);
        keys = 16'h0001 << 3;
        frames(2);
        keys = '0;
        frames(3);
        chk_pulses("bounce_pulses", p0, 0);
        chk_down("bounce_down", 1'b0);
        checks++;
        if (key_code !== 4'd0) begin
            errors++;
            $display("FAIL bounce_code: got %0d, required 0", key_code);
        end
    endtask

    task automatic test_multi();
        int p0;
        keys = '0;
        do_reset();
        p0 = pulses;
        keys = (16'h0001 << 0) | (16'h0001 << 5);
        frames(6);
        chk_pulses("multi_none", p0, 0);
        chk_down("multi_down", 1'b0);
        keys = 16'h0001 << 5;
        exp_q.push_back(4'd5);
        frames(2);
        chk_down("multi_single_f2", 1'b0);
        frames(1);
        chk_down("multi_single_f3", 1'b1);
        checks++;
        if (key_code !== 4'd5) begin
            errors++;
            $display("FAIL multi_code: got %0d, required 5", key_code);
        end
        @(negedge clk);
        chk_pulses("multi_pulses", p0, 1);
    endtask

    task automatic test_release_bounce();
        int p0;
        keys = '0;
        do_reset();
        p0 = pulses;
        keys = 16'h0001 << 15;
        exp_q.push_back(4'd15);
        frames(3);
        chk_down("rb_press", 1'b1);
        checks++;
        if (key_code !== 4'd15) begin
            errors++;
            $display("FAIL rb_code: got %0d, required 15", key_code);
        end
        keys = '0;
        frames(2);
        chk_down("rb_rel2", 1'b1);
        keys = 16'h0001 << 15;
        frames(1);
        chk_down("rb_glitch", 1'b1);
        keys = '0;
        frames(2);
        chk_down("rb_rel_f2", 1'b1);
        frames(1);
        chk_down("rb_rel_f3", 1'b0);
        frames(1);
        chk_pulses("rb_pulses", p0, 1);
    endtask

    task automatic test_reset_deb();
        int p0;
        do_reset();
        checks++;
        if (key_code !== 4'd0) begin
            errors++;
            $display("FAIL rd_reset_code: got %0d, required 0", key_code);
        end
        p0 = pulses;
        keys = 16'h0001 << 8;
        frames(2);
        do_reset();
        chk_pulses("rd_no_pulse", p0, 0);
        exp_q.push_back(4'd8);
        frames(2);
        chk_down("rd_f2", 1'b0);
        frames(1);
        chk_down("rd_f3", 1'b1);
        checks++;
        if (key_code !== 4'd8) begin
            errors++;
            $display("FAIL rd_code: got %0d, required 8", key_code);
        end
        @(negedge clk);
        chk_pulses("rd_pulses", p0, 1);
        keys = '0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi();
        test_release_bounce();
        test_reset_deb();
        frames(1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_vld: %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- 4x4 matrix keypad scanner with debounce for the Runber board.
- Drives keypad columns active-low, samples the active-low rows, and debounces per scan frame.
- Outputs an accepted 4-bit key code with a one-cycle valid strobe.
- Input-side companion of the 4-digit seven-segment display driver; key_code feeds its 4-bit key input.

Parameters:
- SCAN_DIV, 50000, clk cycles each column is held low (1 ms at 50 MHz); minimum 2.
- DB_CNT, 5, consecutive identical frames needed to accept a press or a release; minimum 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- row  input  4  keypad rows; active-low, externally pulled up.
- col  output 4  keypad column drive; active-low, exactly one bit low.
- key_code  output 4  last accepted key, code = 4*r + c.
- key_vld  output 1  one-cycle pulse on each accepted press.
- key_down  output 1  high while the accepted key is held (debounced).

Behaviour:
- Reset values (asynchronous): col=4'b1110, key_code=0, key_vld=0, key_down=0, state IDLE, all counters 0, row synchronizer 4'b1111.
- Row synchronization: row passes through a 2-flop synchronizer; only the synchronized value is used.
- Column scan:
  - col sequence is 1110 -> 1101 -> 1011 -> 0111 -> 1110, column index c = 0..3.
  - Each column is driven for SCAN_DIV cycles.
  - Synchronized rows are sampled on the last cycle of each dwell, allowing settling time.
- Frame: 4 column dwells (4*SCAN_DIV cycles). At frame end the frame result is one of:
  - NONE: no zero row bit in any sample.
  - SINGLE(k): exactly one pressed (r,c) pair, with k = 4*r + c.
  - MULTI: two or more pressed pairs.
- FSM, evaluated once per frame end:
  - IDLE: SINGLE(k) -> DEB_P with cand=k, cnt=1. NONE or MULTI -> stay.
  - DEB_P: SINGLE(cand) -> cnt+1. When cnt reaches DB_CNT -> PRESSED, key_code=cand, key_vld=1 for one cycle, key_down=1. Any other result -> IDLE, with no output change.
  - PRESSED: NONE -> DEB_R with cnt=1. SINGLE(any) or MULTI -> stay. No auto-repeat, and no new pulse for a second key.
  - DEB_R: NONE -> cnt+1. When cnt reaches DB_CNT -> IDLE, key_down=0. SINGLE or MULTI -> PRESSED with no pulse.
- DB_CNT=1 edge case: IDLE accepts directly on the first SINGLE frame, and PRESSED releases on the first NONE frame.
- Latency: key_vld and key_down rise in the clk cycle after the frame end of the DB_CNT-th matching frame. key_down falls the same way on release.
- key_code holds its value until the next accepted press; it is not cleared on release.
- Codes 10-15 are valid keypad codes; the display blanks them.
- Reset asserted mid-operation: immediate return to reset values, and the scan restarts at column 0. No pulse is emitted for a partially debounced key.
- Counters: dwell counter wraps 0..SCAN_DIV-1; column index wraps 3 -> 0; debounce cnt saturates at DB_CNT.

Test Plan (SCAN_DIV=4, DB_CNT=3; frame = 16 cycles; bench model drives row[r]=0 when key (r,c) is held and col[c]=0):
- Reset: assert rst mid-scan -> col=1110, key_code=0, key_vld=0, key_down=0 immediately. After release, col steps 1110 -> 1101 every 4 cycles.
- Clean press: hold key (1,2) for 10 frames, then release for 5 frames.
  - Exactly one key_vld pulse, key_code=6, key_down=1 after the 3rd matching frame.
  - key_down=0 after the 3rd empty frame.
  - No second pulse.
- Bounce: key (0,3) held 2 frames, released 1 frame, held 2 frames, then released -> no key_vld, key_code stays 0, key_down stays 0.
- Multi-key: hold keys (0,0) and (1,1) together for 6 frames -> no pulse. Then release (0,0) while keeping (1,1) -> after 3 frames one pulse with key_code=5.
- Release bounce: accept key (3,3) (key_code=15). Then release 2 frames, press 1 frame, release 4 frames -> key_down stays 1 through the glitch and falls after the 3rd consecutive empty frame. Exactly one key_vld pulse in total.
- Reset during DEB_P: hold key (2,0) for 2 frames, pulse rst, keep holding -> no pulse before reset. After reset, a full 3-frame debounce gives a pulse with key_code=8.
